gzip_bit_packer: RTL and testbench

Output bit packer for the gzip compression path. It accepts variable-length bit fields from the Huffman encoder: block header bits, fixed-Huffman literal/length codes, distance codes and extra bits. It concatenates them LSB-first in DEFLATE bit order and writes packed 32-bit words into the output FIFO that the host reads through `dout_out_fifo_32`. A flush request pads the stream to a word boundary so the end of a BFINAL block can be drained.

---
 rtl/gzip_bit_packer.sv | 160 ++++++++++++++++
 tb/tb_gzip_bit_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gzip_bit_packer.sv
// gzip_bit_packer: packs variable-length DEFLATE bit fields LSB-first into 32-bit output words.
// Latency: a field that completes a word shows up on fifo_wr_en/fifo_din two edges after acceptance.
// Backpressure: fifo_afull stalls every write and drops code_ready once more than one word is pending.
// Build option: define GZIP_PACKER_BYTE_SWAP_EN to put the first stream byte in fifo_din[31:24].
module gzip_bit_packer #(
  parameter int CODE_WIDTH = 32,
  parameter int ACC_WIDTH  = 64   // must be at least 2*CODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  code_valid,
  input  logic [CODE_WIDTH-1:0] code_bits,
  input  logic [5:0]            code_len,
  output logic                  code_ready,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  input  logic                  fifo_afull,
  output logic                  fifo_wr_en,
  output logic [31:0]           fifo_din,
  output logic [31:0]           out_bytes
);

  localparam int CNT_W = $clog2(ACC_WIDTH + 1);
  localparam int WORD  = 32;

  localparam logic [CNT_W-1:0] WORD_CNT     = CNT_W'(WORD);
  localparam logic [CNT_W-1:0] CODE_LEN_MAX = CNT_W'(CODE_WIDTH);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;        // bits at or above bit_cnt are always zero
  logic [CNT_W-1:0]     bit_cnt;
  logic                 rdy_en;     // holds code_ready low for the first cycle out of reset

  logic [CNT_W-1:0]     len_ext;
  logic [CNT_W-1:0]     len_eff;
  logic [ACC_WIDTH-1:0] field_ext;
  logic                 take;
  logic                 wr_now;
  logic                 last_now;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [CNT_W-1:0]     cnt_base;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [CNT_W-1:0]     pad_bytes;
  logic [31:0]          add_bytes;

  // Output word byte order; the swapped order matches the host's word swap.
  function automatic logic [31:0] pack_word(input logic [31:0] w);
`ifdef GZIP_PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Accept new fields only in RUN while at most one full word is pending.
  always_comb begin
    code_ready = rst_n && rdy_en && (state == ST_RUN) && (bit_cnt <= WORD_CNT);
  end

  // Clamp the length to CODE_WIDTH and mask off bits at or above it.
  always_comb begin
    len_ext   = CNT_W'(code_len);
    len_eff   = (len_ext > CODE_LEN_MAX) ? CODE_LEN_MAX : len_ext;
    field_ext = ACC_WIDTH'(code_bits) & ~({ACC_WIDTH{1'b1}} << len_eff);
    take      = code_valid && code_ready;
  end

  // Decide this cycle's write and whether it ends a flush.
  always_comb begin
    wr_now   = 1'b0;
    last_now = 1'b0;
    if (state == ST_RUN) begin
      wr_now = (bit_cnt >= WORD_CNT) && !fifo_afull;
    end else begin
      // In FLUSH, any pending bits are written; a word holding 32 or fewer
      // bits is the last one, and an empty accumulator finishes immediately.
      wr_now   = (bit_cnt != '0) && !fifo_afull;
      last_now = (bit_cnt <= WORD_CNT) && ((bit_cnt == '0) || !fifo_afull);
    end
  end

  // Retire the written word, then place any accepted field above what remains.
  always_comb begin
    acc_base = acc;
    cnt_base = bit_cnt;
    if (wr_now) begin
      acc_base = acc >> WORD;
      if (bit_cnt >= WORD_CNT) begin
        cnt_base = bit_cnt - WORD_CNT;
      end else begin
        cnt_base = '0;
      end
    end
    acc_nxt = acc_base;
    cnt_nxt = cnt_base;
    if (take) begin
      acc_nxt = acc_base | (field_ext << cnt_base);
      cnt_nxt = cnt_base + len_eff;
    end
  end

  // Bytes credited per write: 4 for a full word, only the occupied bytes for a padded one.
  always_comb begin
    pad_bytes = (bit_cnt + CNT_W'(7)) >> 3;
    add_bytes = (bit_cnt >= WORD_CNT) ? 32'd4 : 32'(pad_bytes);
  end

  // State, accumulator and registered outputs; reset drops any pending bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      acc        <= '0;
      bit_cnt    <= '0;
      rdy_en     <= 1'b0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      out_bytes  <= '0;
    end else begin
      rdy_en     <= 1'b1;
      acc        <= acc_nxt;
      bit_cnt    <= cnt_nxt;
      fifo_wr_en <= wr_now;
      flush_done <= 1'b0;
      if (wr_now) begin
        // Bits above bit_cnt are zero already, so a padded word needs no extra masking.
        fifo_din  <= pack_word(acc[31:0]);
        out_bytes <= out_bytes + add_bytes;
      end
      case (state)
        ST_RUN: begin
          if (flush_req) begin
            state      <= ST_FLUSH;
            flush_busy <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (last_now) begin
            state      <= ST_RUN;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end
        end
        default: begin
          state      <= ST_RUN;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gzip_bit_packer.sv
// Testbench for gzip_bit_packer: directed steps, expected words queued at drive time.
// Expected words are popped as writes appear; timing and counters are checked inline.
// Backpressure is exercised by holding fifo_afull around a multi-word burst.
module tb_gzip_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_valid = 1'b0;
  logic [31:0] code_bits = '0;
  logic [5:0]  code_len = '0;
  logic        code_ready;
  logic        flush_req = 1'b0;
  logic        flush_busy;
  logic        flush_done;
  logic        fifo_afull = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic [31:0] out_bytes;

  int          total = 0;
  int          bad = 0;
  int          wr_count = 0;
  int          exp_bytes = 0;
  int          wr_snap;
  int          dn;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  gzip_bit_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .code_ready (code_ready),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .fifo_afull (fifo_afull),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .out_bytes  (out_bytes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef GZIP_PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Scoreboard: every write must match the oldest expected word.
  always @(posedge clk) begin
    #2;
    if (fifo_wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", fifo_din, 32'hFFFF_FFFF ^ fifo_din);
      end else begin
        check("word", fifo_din, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [31:0] b, input logic [5:0] l);
    int n = 0;
    code_valid = 1'b1;
    code_bits  = b;
    code_len   = l;
    while (code_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_wr, output int cycles);
    int n = 0;
    while (flush_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cycles = n;
    check({tag, "_done_seen"}, 32'(flush_done), 32'd1);
    check({tag, "_wr_with_done"}, 32'(fifo_wr_en), 32'(exp_wr));
    @(negedge clk);
  endtask

  task automatic wait_wr(input string tag, input int target);
    int n = 0;
    while (wr_count < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wr_count"}, 32'(wr_count), 32'(target));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(code_ready), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_din", fifo_din, 32'd0);
    check("rst_busy", 32'(flush_busy), 32'd0);
    check("rst_done", 32'(flush_done), 32'd0);
    check("rst_bytes", out_bytes, 32'd0);
    rst_n = 1'b1;
    check("ready_before_edge", 32'(code_ready), 32'd0);
    @(negedge clk);
    check("ready_after_rst", 32'(code_ready), 32'd1);

    // Four back-to-back bytes form one word with two-edge latency
    exp_q.push_back(ew(32'h2061_6E41));
    send(32'h41, 6'd8);
    send(32'h6E, 6'd8);
    send(32'h61, 6'd8);
    send(32'h20, 6'd8);
    check("lat_not_yet", 32'(fifo_wr_en), 32'd0);
    @(negedge clk);
    check("lat_wr_en", 32'(fifo_wr_en), 32'd1);
    exp_bytes += 4;
    check("s1_bytes", out_bytes, 32'(exp_bytes));

    // Three bits then flush: padded word with done in the same cycle
    exp_q.push_back(ew(32'h0000_0003));
    send(32'h3, 6'd3);
    flush();
    check("s2_busy", 32'(flush_busy), 32'd1);
    check("s2_ready_busy", 32'(code_ready), 32'd0);
    wait_done("s2", 1'b1, dn);
    exp_bytes += 1;
    check("s2_bytes", out_bytes, 32'(exp_bytes));
    check("s2_busy_clear", 32'(flush_busy), 32'd0);

    // 30 + 5 bits spanning a word boundary, then flush
    exp_q.push_back(ew(32'h7FFF_FFFF));
    exp_q.push_back(ew(32'h0000_0005));
    send(32'h3FFF_FFFF, 6'd30);
    send(32'h15, 6'd5);
    flush();
    wait_done("s3", 1'b1, dn);
    exp_bytes += 5;
    check("s3_bytes", out_bytes, 32'(exp_bytes));

    // Flush with an empty accumulator: done one cycle after acceptance, no write
    wr_snap = wr_count;
    flush();
    wait_done("empty", 1'b0, dn);
    check("empty_done_cycles", 32'(dn), 32'd1);
    check("empty_no_write", 32'(wr_count), 32'(wr_snap));
    check("empty_bytes", out_bytes, 32'(exp_bytes));

    // Length 0 ignored, length above 32 clamped, bits above length masked
    exp_q.push_back(ew(32'hDEAD_BEEF));
    exp_q.push_back(ew(32'h0000_000F));
    exp_q.push_back(ew(32'h0000_005A));
    send(32'hFFFF_FFFF, 6'd0);
    send(32'hDEAD_BEEF, 6'd40);
    send(32'hFFFF_FFFF, 6'd4);
    send(32'h0000_0000, 6'd28);
    send(32'hFFFF_FF5A, 6'd8);
    flush();
    wait_done("mask", 1'b1, dn);
    exp_bytes += 9;
    check("mask_bytes", out_bytes, 32'(exp_bytes));

    // Backpressure: afull holds writes; ready drops once more than 32 bits pend
    exp_q.push_back(ew(32'h4433_2211));
    exp_q.push_back(ew(32'h8877_6655));
    wr_snap = wr_count;
    fifo_afull = 1'b1;
    send(32'h11, 6'd8);
    send(32'h22, 6'd8);
    send(32'h33, 6'd8);
    send(32'h44, 6'd8);
    send(32'h55, 6'd8);
    code_valid = 1'b1;
    code_bits  = 32'h66;
    code_len   = 6'd8;
    repeat (10) @(negedge clk);
    check("afull_ready_low", 32'(code_ready), 32'd0);
    check("afull_no_write", 32'(wr_count), 32'(wr_snap));
    fifo_afull = 1'b0;
    send(32'h66, 6'd8);
    send(32'h77, 6'd8);
    send(32'h88, 6'd8);
    wait_wr("afull", wr_snap + 2);
    @(negedge clk);
    exp_bytes += 8;
    check("afull_bytes", out_bytes, 32'(exp_bytes));

    // Reset while 20 bits pend and a flush is stalled
    fifo_afull = 1'b1;
    send(32'h000A_BCDE, 6'd20);
    flush();
    check("mid_busy", 32'(flush_busy), 32'd1);
    wr_snap = wr_count;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(code_ready), 32'd0);
    check("mid_rst_busy", 32'(flush_busy), 32'd0);
    check("mid_rst_done", 32'(flush_done), 32'd0);
    check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("mid_rst_din", fifo_din, 32'd0);
    check("mid_rst_bytes", out_bytes, 32'd0);
    rst_n = 1'b1;
    fifo_afull = 1'b0;
    exp_bytes = 0;
    repeat (3) @(negedge clk);
    check("mid_no_write", 32'(wr_count), 32'(wr_snap));
    exp_q.push_back(ew(32'h0000_00AB));
    send(32'hAB, 6'd8);
    flush();
    wait_done("post_rst", 1'b1, dn);
    exp_bytes += 1;
    check("post_rst_bytes", out_bytes, 32'(exp_bytes));

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
